// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD pixel path: reader FSM state encoding, word
// and pixel widths, and the helper that picks one RGB565 half out of a
// 32-bit FIFO word.
// No ports (package).
// ----------------------------------------------------------------------------
package lcd_pkg;

    localparam int PIXEL_W = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nothing held
        WAIT = 2'd1,  // read in flight, no word held
        PIX0 = 2'd2,  // first half of cur on the output
        PIX1 = 2'd3   // second half of cur on the output
    } state_t;

    // Returns the half of 'word' emitted in the first (second = 0) or second
    // (second = 1) pixel slot. low_first selects which half leads.
    function automatic logic [PIXEL_W-1:0] pixel_half(
        input logic [WORD_W-1:0] word,
        input logic              second,
        input logic              low_first
    );
        return (second ^ low_first) ? word[PIXEL_W-1:0] : word[WORD_W-1:PIXEL_W];
    endfunction

endpackage

// File: rtl/read_latency_tracker.sv
// ----------------------------------------------------------------------------
// read_latency_tracker
// Follows each FIFO read strobe through the FIFO's read latency so the reader
// knows when i_fifoData carries the requested word and whether a read is
// still outstanding.
//
// Ports:
//   i_clock       in  1  system clock, rising edge
//   i_reset       in  1  asynchronous active-high reset
//   read_issued   in  1  registered read strobe as seen by the FIFO
//   dataArrive    out 1  i_fifoData holds the requested word this cycle
//   inflight_any  out 1  a read is outstanding that does not complete this
//                        cycle (the strobe itself or an earlier stage)
// ----------------------------------------------------------------------------
module read_latency_tracker #(
    parameter int READ_LATENCY = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic read_issued,
    output logic dataArrive,
    output logic inflight_any
);

    // inflight[k] set: the strobe was high k+1 cycles ago.
    logic [READ_LATENCY-1:0] inflight;

    // NOTE: the stages are cleared on reset rather than left to power up
    // unknown; a read pending at reset must never look like returning data.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            inflight <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, giving a true shift register.
            inflight[0] <= read_issued;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    assign dataArrive = inflight[READ_LATENCY-1];

    // The completing stage is excluded so a follow-up read can be decided in
    // the arrival cycle; that is what keeps a latency-1 stream gap-free.
    always_comb begin
        inflight_any = read_issued;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            inflight_any = inflight_any | inflight[i];
        end
    end

endmodule

// File: rtl/fifo_pixel_reader.sv
// ----------------------------------------------------------------------------
// fifo_pixel_reader
// Drains 32-bit words from a fifo_32 read port and emits each as two RGB565
// pixels on a valid/ready handshake. A one-word prefetch register (nxt) hides
// the FIFO read latency so the pixel stream stays gap-free while data lasts.
//
// Parameters:
//   READ_LATENCY  cycles from o_fifoRead to valid i_fifoData (1..3)
//   LOW_FIRST     1: bits [15:0] first, 0: bits [31:16] first
//
// Ports:
//   i_clock          in  1   system clock, rising edge
//   i_reset          in  1   asynchronous active-high reset
//   i_fifoEmpty      in  1   FIFO empty flag
//   i_fifoData       in  32  FIFO read data
//   o_fifoRead       out 1   single-cycle registered read strobe
//   o_pixelData      out 16  current pixel
//   o_pixelValid     out 1   o_pixelData valid
//   i_pixelReady     in  1   consumer takes the pixel this cycle
//   o_busy           out 1   a word is held, prefetched or in flight
//   o_underrun       out 1   sticky underrun flag     (macro build only)
//   i_clearUnderrun  in  1   clears o_underrun        (macro build only)
//
// Build option: define FIFO_PIXEL_READER_UNDERRUN_EN to add the underrun
// flag and its clear input. Pixel behaviour is the same in both builds.
// ----------------------------------------------------------------------------
module fifo_pixel_reader
    import lcd_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int LOW_FIRST    = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_fifoEmpty,
    input  logic [WORD_W-1:0]  i_fifoData,
    output logic               o_fifoRead,
    output logic [PIXEL_W-1:0] o_pixelData,
    output logic               o_pixelValid,
    input  logic               i_pixelReady,
`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
    output logic               o_underrun,
    input  logic               i_clearUnderrun,
`endif
    output logic               o_busy
);

    localparam logic LOW_FIRST_B = (LOW_FIRST != 0);

    state_t              state;
    state_t              state_d;
    logic [WORD_W-1:0]   cur;
    logic [WORD_W-1:0]   cur_d;
    logic [WORD_W-1:0]   nxt;
    logic [WORD_W-1:0]   nxt_d;
    logic                nxt_valid;
    logic                nxt_valid_d;
    logic [PIXEL_W-1:0]  pixel_d;

    logic                accept;
    logic                issue;
    logic                load_cur;
    logic                load_nxt;
    logic                data_arrive;
    logic                inflight_any;

    read_latency_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tracker (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .read_issued  (o_fifoRead),
        .dataArrive   (data_arrive),
        .inflight_any (inflight_any)
    );

    assign accept = o_pixelValid && i_pixelReady;

    // Returning data goes to nxt unless it is consumed straight into cur:
    // in WAIT, or when the second pixel is taken with nothing prefetched.
    // Only one read is ever outstanding and it is only issued with nxt empty,
    // so an arrival never meets a full nxt.
    assign load_nxt = data_arrive &&
                      ((state == PIX0) || ((state == PIX1) && !accept));

    // A read may be decided in the arrival cycle of the previous one, but not
    // when that arrival is filling nxt: the new word would have nowhere to go.
    assign issue = !i_fifoEmpty && !inflight_any && !nxt_valid && !load_nxt;

    // Next-state, word registers and prefetch flag.
    always_comb begin
        // NOTE: every signal gets its default before the case so no path
        // leaves one unassigned; that is what keeps this block latch-free.
        state_d     = state;
        cur_d       = cur;
        nxt_d       = nxt;
        nxt_valid_d = nxt_valid;
        load_cur    = 1'b0;

        case (state)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_arrive) begin
                    cur_d    = i_fifoData;
                    load_cur = 1'b1;
                    state_d  = PIX0;
                end
            end
            PIX0: begin
                if (accept) begin
                    state_d = PIX1;
                end
            end
            PIX1: begin
                if (accept) begin
                    if (nxt_valid) begin
                        cur_d       = nxt;
                        nxt_valid_d = 1'b0;
                        state_d     = PIX0;
                    end else if (data_arrive) begin
                        cur_d    = i_fifoData;
                        load_cur = 1'b1;
                        state_d  = PIX0;
                    end else if (inflight_any) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_nxt) begin
            nxt_d       = i_fifoData;
            nxt_valid_d = 1'b1;
        end
    end

    // The pixel register is loaded from the next state and next cur, so it
    // always matches o_pixelValid and holds while the consumer stalls.
    always_comb begin
        pixel_d = '0;
        case (state_d)
            PIX0:    pixel_d = pixel_half(cur_d, 1'b0, LOW_FIRST_B);
            PIX1:    pixel_d = pixel_half(cur_d, 1'b1, LOW_FIRST_B);
            default: pixel_d = '0;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cur         <= '0;
            nxt         <= '0;
            nxt_valid   <= 1'b0;
            o_fifoRead  <= 1'b0;
            o_pixelData <= '0;
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            nxt         <= nxt_d;
            nxt_valid   <= nxt_valid_d;
            o_fifoRead  <= issue;
            o_pixelData <= pixel_d;
        end
    end

    assign o_pixelValid = (state == PIX0) || (state == PIX1);
    assign o_busy       = (state != IDLE) || nxt_valid || inflight_any;

`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
    // Underrun only counts once the first word has been delivered, so the
    // start-up wait for data never raises the flag. Set beats clear.
    logic started;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            started    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (load_cur) begin
                started <= 1'b1;
            end
            if (started && i_pixelReady && !o_pixelValid) begin
                o_underrun <= 1'b1;
            end else if (i_clearUnderrun) begin
                o_underrun <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_pixel_reader
// Two readers run side by side from shared ready/reset stimulus:
//   lane 0: READ_LATENCY = 1, LOW_FIRST = 1
//   lane 1: READ_LATENCY = 3, LOW_FIRST = 0
// Each lane has a behavioural fifo_32 (a word queue plus a latency delay line)
// and an expected-pixel queue filled from the words pushed into the FIFO.
// Define FIFO_PIXEL_READER_UNDERRUN_EN to also exercise the underrun flag.
// ----------------------------------------------------------------------------
module tb_fifo_pixel_reader;

    localparam int N_DUT = 2;

    logic clk = 1'b0;
    logic rst;
    logic ready;
`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
    logic clear_underrun;
    logic underrun [N_DUT];
`endif

    logic        fifo_empty [N_DUT];
    logic [31:0] fifo_data  [N_DUT];
    logic        fifo_read  [N_DUT];
    logic [15:0] pixel      [N_DUT];
    logic        valid      [N_DUT];
    logic        busy       [N_DUT];

    logic [31:0] fifo_q [N_DUT][$];  // words still stored in the FIFO
    logic [15:0] exp_q  [N_DUT][$];  // pixels still owed to the consumer

    int n_rd        [N_DUT];
    int n_acc       [N_DUT];
    int first_rd    [N_DUT];
    int first_valid [N_DUT];
    int first_acc   [N_DUT];
    int last_acc    [N_DUT];

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic bit low_first_of(input int g);
        return (g == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Puts a word into a lane's FIFO and records the two pixels it must yield.
    task automatic push_word(input int g, input logic [31:0] w);
        fifo_q[g].push_back(w);
        if (low_first_of(g)) begin
            exp_q[g].push_back(w[15:0]);
            exp_q[g].push_back(w[31:16]);
        end else begin
            exp_q[g].push_back(w[31:16]);
            exp_q[g].push_back(w[15:0]);
        end
    endtask

    task automatic clear_stats();
        for (int g = 0; g < N_DUT; g++) begin
            n_rd[g]        = 0;
            n_acc[g]       = 0;
            first_rd[g]    = -1;
            first_valid[g] = -1;
            first_acc[g]   = -1;
            last_acc[g]    = -1;
        end
    endtask

    // Stimulus changes 2 time units after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit all_drained();
        return exp_q[0].size() == 0 && exp_q[1].size() == 0 && !busy[0] && !busy[1];
    endfunction

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !all_drained()) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    for (genvar g = 0; g < N_DUT; g++) begin : lane
        localparam int L = lat_of(g);

        logic [31:0] pipe [3];
        logic        rd_seen    = 1'b0;
        logic        rd_prev    = 1'b0;
        logic        stall_prev = 1'b0;
        logic [15:0] pix_prev   = '0;
        int          last_rd    = -1;

        fifo_pixel_reader #(
            .READ_LATENCY (L),
            .LOW_FIRST    (low_first_of(g) ? 1 : 0)
        ) dut (
            .i_clock         (clk),
            .i_reset         (rst),
            .i_fifoEmpty     (fifo_empty[g]),
            .i_fifoData      (fifo_data[g]),
            .o_fifoRead      (fifo_read[g]),
            .o_pixelData     (pixel[g]),
            .o_pixelValid    (valid[g]),
            .i_pixelReady    (ready),
`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
            .o_underrun      (underrun[g]),
            .i_clearUnderrun (clear_underrun),
`endif
            .o_busy          (busy[g])
        );

        // FIFO model (pop at +1, empty flag at +3) and output monitor (negedge).
        initial begin
            fifo_empty[g] = 1'b1;
            fifo_data[g]  = '0;
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            forever begin
                @(posedge clk);
                #1;
                for (int i = 2; i > 0; i--) pipe[i] = pipe[i-1];
                if (rd_seen) begin
                    check("read_while_empty", 32'(fifo_q[g].size() != 0), 32'd1);
                    pipe[0] = (fifo_q[g].size() != 0) ? fifo_q[g].pop_front() : 32'hDEAD_BEEF;
                    rd_seen = 1'b0;
                end else begin
                    pipe[0] = 32'h0BAD_0BAD;
                end
                fifo_data[g] = pipe[L-1];
                #2;
                fifo_empty[g] = (fifo_q[g].size() == 0);

                @(negedge clk);
                if (rst) begin
                    rd_seen    = 1'b0;
                    rd_prev    = 1'b0;
                    stall_prev = 1'b0;
                    last_rd    = -1;
                end else begin
                    rd_seen = fifo_read[g];
                    if (fifo_read[g]) begin
                        check("read_back_to_back", 32'(rd_prev), 32'd0);
                        if (last_rd >= 0)
                            check("read_outstanding", 32'((cycle - last_rd) > L), 32'd1);
                        last_rd = cycle;
                        n_rd[g]++;
                        if (first_rd[g] < 0) first_rd[g] = cycle;
                    end
                    if (stall_prev) begin
                        check("hold_valid", 32'(valid[g]), 32'd1);
                        check("hold_data", 32'(pixel[g]), 32'(pix_prev));
                    end
                    if (valid[g] && first_valid[g] < 0) first_valid[g] = cycle;
                    if (valid[g] && ready) begin
                        check("pixel_expected", 32'(exp_q[g].size() != 0), 32'd1);
                        if (exp_q[g].size() != 0)
                            check("pixel_data", 32'(pixel[g]), 32'(exp_q[g].pop_front()));
                        n_acc[g]++;
                        if (first_acc[g] < 0) first_acc[g] = cycle;
                        last_acc[g] = cycle;
                    end
                    rd_prev    = fifo_read[g];
                    stall_prev = valid[g] && !ready;
                    pix_prev   = pixel[g];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (tests run %0d)", tests_run);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int owed [N_DUT];

        rst   = 1'b1;
        ready = 1'b0;
`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
        clear_underrun = 1'b0;
`endif
        clear_stats();
        tick(3);

        // Reset values.
        for (int g = 0; g < N_DUT; g++) begin
            check("reset_valid", 32'(valid[g]), 32'd0);
            check("reset_pixel", 32'(pixel[g]), 32'd0);
            check("reset_read", 32'(fifo_read[g]), 32'd0);
            check("reset_busy", 32'(busy[g]), 32'd0);
`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
            check("reset_underrun", 32'(underrun[g]), 32'd0);
`endif
        end
        tick(1);
        rst = 1'b0;
        tick(2);

        // Single word per lane, ready high.
        clear_stats();
        ready = 1'b1;
        push_word(0, 32'hAAAA_5555);
        push_word(1, 32'h1234_5678);
        wait_drain(100, "single_drain");
        for (int g = 0; g < N_DUT; g++) begin
            check("single_reads", 32'(n_rd[g]), 32'd1);
            check("single_pixels", 32'(n_acc[g]), 32'd2);
            check("single_latency", 32'(first_valid[g] - first_rd[g]), 32'(lat_of(g) + 1));
            check("single_busy", 32'(busy[g]), 32'd0);
        end

        // Sustained stream of 50 incrementing words, ready high.
        clear_stats();
        for (int i = 0; i < 50; i++) begin
            for (int g = 0; g < N_DUT; g++)
                push_word(g, 32'h1000_0000 + 32'(i) * 32'h0001_0001);
        end
        wait_drain(1000, "stream_drain");
        for (int g = 0; g < N_DUT; g++) begin
            check("stream_pixels", 32'(n_acc[g]), 32'd100);
            check("stream_latency", 32'(first_valid[g] - first_rd[g]), 32'(lat_of(g) + 1));
        end
        check("stream_gap_free", 32'(last_acc[0] - first_acc[0]), 32'd99);

        // Random back-pressure on 20 random words.
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            for (int g = 0; g < N_DUT; g++) push_word(g, $urandom);
        end
        for (int n = 0; n < 3000 && !all_drained(); n++) begin
            ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        ready = 1'b1;
        wait_drain(200, "backpressure_drain");
        for (int g = 0; g < N_DUT; g++)
            check("backpressure_pixels", 32'(n_acc[g]), 32'd40);

        // Reset in PIX1 with a word prefetched and one word left in the FIFO.
        clear_stats();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < N_DUT; g++) push_word(g, $urandom);
        end
        tick(14);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            check("midreset_valid", 32'(valid[g]), 32'd0);
            check("midreset_pixel", 32'(pixel[g]), 32'd0);
            check("midreset_read", 32'(fifo_read[g]), 32'd0);
            check("midreset_busy", 32'(busy[g]), 32'd0);
        end
        // Held and in-flight words are lost; only what the FIFO still stores
        // can come out after reset.
        for (int g = 0; g < N_DUT; g++) begin
            exp_q[g].delete();
            foreach (fifo_q[g][i]) begin
                if (low_first_of(g)) begin
                    exp_q[g].push_back(fifo_q[g][i][15:0]);
                    exp_q[g].push_back(fifo_q[g][i][31:16]);
                end else begin
                    exp_q[g].push_back(fifo_q[g][i][31:16]);
                    exp_q[g].push_back(fifo_q[g][i][15:0]);
                end
            end
            owed[g] = exp_q[g].size();
        end
        tick(1);
        check("midreset_valid_held", 32'(valid[0] | valid[1]), 32'd0);
        rst = 1'b0;
        clear_stats();
        ready = 1'b1;
        wait_drain(200, "post_reset_drain");
        for (int g = 0; g < N_DUT; g++) begin
            check("post_reset_owed", 32'(owed[g]), 32'd2);
            check("post_reset_pixels", 32'(n_acc[g]), 32'(owed[g]));
        end

`ifdef FIFO_PIXEL_READER_UNDERRUN_EN
        // FIFO drained with ready high: underrun sets and stays set.
        tick(3);
        for (int g = 0; g < N_DUT; g++)
            check("underrun_set", 32'(underrun[g]), 32'd1);
        ready = 1'b0;
        tick(3);
        for (int g = 0; g < N_DUT; g++)
            check("underrun_sticky", 32'(underrun[g]), 32'd1);
        clear_underrun = 1'b1;
        tick(1);
        clear_underrun = 1'b0;
        for (int g = 0; g < N_DUT; g++)
            check("underrun_cleared", 32'(underrun[g]), 32'd0);
        ready          = 1'b1;
        clear_underrun = 1'b1;
        tick(1);
        clear_underrun = 1'b0;
        ready          = 1'b0;
        for (int g = 0; g < N_DUT; g++)
            check("underrun_set_wins", 32'(underrun[g]), 32'd1);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
